// File: rtl/mem_issue_sched_if.sv
// Issue-queue / LSU / flush bundle for mem_issue_sched.
// slave  : scheduler side (consumes isq + resp + flush, drives lsu_req + isq_deq_ready)
// master : environment side (issue queue, LSU, flush source)
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

interface mem_issue_sched_if #(
    parameter int unsigned DATA_WIDTH   = 248,
    parameter int unsigned ISQ_ID_WIDTH = 4,
    parameter int unsigned ROBID_WIDTH  = `ROB_SIZE_LOG + 1
);
    logic                    isq_deq_valid;
    logic                    isq_deq_ready;
    logic [DATA_WIDTH-1:0]   isq_deq_data;
    logic [ROBID_WIDTH-1:0]  isq_deq_robid;
    logic [ISQ_ID_WIDTH-1:0] isq_deq_id;

    logic                    lsu_req_valid;
    logic                    lsu_req_ready;
    logic [DATA_WIDTH-1:0]   lsu_req_data;
    logic [ROBID_WIDTH-1:0]  lsu_req_robid;
    logic [ISQ_ID_WIDTH-1:0] lsu_req_id;
    logic                    lsu_req_is_replay;

    logic                    lsu_resp_valid;
    logic                    lsu_resp_replay;
    logic [DATA_WIDTH-1:0]   lsu_resp_data;
    logic [ROBID_WIDTH-1:0]  lsu_resp_robid;
    logic [ISQ_ID_WIDTH-1:0] lsu_resp_id;

    logic                    flush_valid;
    logic [ROBID_WIDTH-1:0]  flush_robid;

    modport slave (
        input  isq_deq_valid, isq_deq_data, isq_deq_robid, isq_deq_id,
        output isq_deq_ready,
        output lsu_req_valid, lsu_req_data, lsu_req_robid, lsu_req_id, lsu_req_is_replay,
        input  lsu_req_ready,
        input  lsu_resp_valid, lsu_resp_replay, lsu_resp_data, lsu_resp_robid, lsu_resp_id,
        input  flush_valid, flush_robid
    );

    modport master (
        output isq_deq_valid, isq_deq_data, isq_deq_robid, isq_deq_id,
        input  isq_deq_ready,
        input  lsu_req_valid, lsu_req_data, lsu_req_robid, lsu_req_id, lsu_req_is_replay,
        output lsu_req_ready,
        output lsu_resp_valid, lsu_resp_replay, lsu_resp_data, lsu_resp_robid, lsu_resp_id,
        output flush_valid, flush_robid
    );
endinterface

// File: rtl/mem_issue_sched.sv
// Memory issue scheduler: arbitrates the single LSU issue slot between new
// issue-queue uops and LSU-bounced replays, keeps the replay buffer, enforces
// the in-flight credit limit and kills uops younger than a flush point.
// Ports: clock, reset_n (sync, active-low), bus (mem_issue_sched_if.slave),
//        inflight_cnt (credits in use), sched_idle (no credits used, stage empty).
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

module mem_issue_sched #(
    parameter int unsigned DATA_WIDTH   = 248,
    parameter int unsigned ISQ_ID_WIDTH = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned REPLAY_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    mem_issue_sched_if.slave                 bus,
    output logic [$clog2(MAX_INFLIGHT):0]    inflight_cnt,
    output logic                             sched_idle
);
    localparam int unsigned ROBID_W = `ROB_SIZE_LOG + 1;
    localparam int unsigned CNT_W   = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned IDX_W   = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;

    if (REPLAY_DEPTH < MAX_INFLIGHT) begin : g_depth_check
        $error("mem_issue_sched: REPLAY_DEPTH must be >= MAX_INFLIGHT");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [ROBID_W-1:0]      robid;
        logic [ISQ_ID_WIDTH-1:0] id;
    } uop_t;

    // a younger than b, robid MSB is the wrap bit
    function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1]) return a[ROBID_W-2:0] > b[ROBID_W-2:0];
        else                              return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    endfunction

    logic                    out_valid_q, out_valid_d;
    logic                    out_replay_q, out_replay_d;
    uop_t                    out_uop_q, out_uop_d;
    logic [REPLAY_DEPTH-1:0] rb_valid_q, rb_valid_d;
    uop_t                    rb_uop_q [REPLAY_DEPTH];
    uop_t                    rb_uop_d [REPLAY_DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    rb_any, free_any, stage_free;
    logic [IDX_W-1:0]        rb_sel, free_idx;
    logic [ROBID_W-1:0]      rb_best;
    logic                    isq_ready_c, isq_load, rb_load;
    logic                    resp_bounce, resp_drop, resp_done, rb_wr;
    int unsigned             kills;
    int                      cnt_next;

    // Arbitration, flush kill, replay write and credit accounting
    always_comb begin
        rb_any   = 1'b0;
        rb_sel   = '0;
        rb_best  = '0;
        free_any = 1'b0;
        free_idx = '0;
        kills    = 0;

        out_valid_d  = out_valid_q;
        out_replay_d = out_replay_q;
        out_uop_d    = out_uop_q;
        rb_valid_d   = rb_valid_q;
        rb_uop_d     = rb_uop_q;

        // oldest valid replay entry
        for (int i = 0; i < int'(REPLAY_DEPTH); i++) begin
            if (rb_valid_q[i] && (!rb_any || younger(rb_best, rb_uop_q[i].robid))) begin
                rb_any  = 1'b1;
                rb_sel  = IDX_W'(i);
                rb_best = rb_uop_q[i].robid;
            end
        end
        // lowest free replay index
        for (int i = int'(REPLAY_DEPTH) - 1; i >= 0; i--) begin
            if (!rb_valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end

        stage_free  = !out_valid_q || bus.lsu_req_ready;
        isq_ready_c = reset_n && stage_free && !rb_any
                      && (cnt_q < CNT_W'(MAX_INFLIGHT)) && !bus.flush_valid;
        isq_load    = isq_ready_c && bus.isq_deq_valid;
        rb_load     = stage_free && rb_any && !bus.flush_valid;

        if (bus.flush_valid) begin
            // no loads this cycle; a surviving stage entry may still hand off
            if (out_valid_q && younger(out_uop_q.robid, bus.flush_robid)) begin
                out_valid_d = 1'b0;
                kills       = kills + 1;
            end else if (bus.lsu_req_ready) begin
                out_valid_d = 1'b0;
            end
            for (int i = 0; i < int'(REPLAY_DEPTH); i++) begin
                if (rb_valid_q[i] && younger(rb_uop_q[i].robid, bus.flush_robid)) begin
                    rb_valid_d[i] = 1'b0;
                    kills         = kills + 1;
                end
            end
        end else if (rb_load) begin
            out_valid_d        = 1'b1;
            out_replay_d       = 1'b1;
            out_uop_d          = rb_uop_q[rb_sel];
            rb_valid_d[rb_sel] = 1'b0;
        end else if (isq_load) begin
            out_valid_d  = 1'b1;
            out_replay_d = 1'b0;
            out_uop_d    = '{data: bus.isq_deq_data, robid: bus.isq_deq_robid, id: bus.isq_deq_id};
        end else if (bus.lsu_req_ready) begin
            out_valid_d = 1'b0;
        end

        resp_bounce = bus.lsu_resp_valid && bus.lsu_resp_replay;
        resp_done   = bus.lsu_resp_valid && !bus.lsu_resp_replay;
        resp_drop   = resp_bounce && bus.flush_valid
                      && younger(bus.lsu_resp_robid, bus.flush_robid);
        rb_wr       = resp_bounce && !resp_drop && free_any;
        if (rb_wr) begin
            rb_valid_d[free_idx] = 1'b1;
            rb_uop_d[free_idx]   = '{data: bus.lsu_resp_data, robid: bus.lsu_resp_robid,
                                     id: bus.lsu_resp_id};
        end

        cnt_next = int'(cnt_q) + int'(isq_load) - int'(resp_done)
                   - int'(kills) - int'(resp_drop);
        cnt_d    = CNT_W'(cnt_next);
    end

    // State registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_replay_q <= 1'b0;
            out_uop_q    <= '0;
            rb_valid_q   <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < int'(REPLAY_DEPTH); i++) rb_uop_q[i] <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_replay_q <= out_replay_d;
            out_uop_q    <= out_uop_d;
            rb_valid_q   <= rb_valid_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < int'(REPLAY_DEPTH); i++) rb_uop_q[i] <= rb_uop_d[i];
        end
    end

    assign bus.isq_deq_ready     = isq_ready_c;
    assign bus.lsu_req_valid     = out_valid_q;
    assign bus.lsu_req_data      = out_uop_q.data;
    assign bus.lsu_req_robid     = out_uop_q.robid;
    assign bus.lsu_req_id        = out_uop_q.id;
    assign bus.lsu_req_is_replay = out_replay_q;
    assign inflight_cnt          = cnt_q;
    assign sched_idle            = (cnt_q == '0) && !out_valid_q;

    a_rb_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(resp_bounce && !resp_drop && !free_any))
        else $error("mem_issue_sched: replay buffer overflow");

    a_cnt_range: assert property (@(posedge clock) disable iff (!reset_n)
        (cnt_next >= 0) && (cnt_next <= int'(MAX_INFLIGHT)))
        else $error("mem_issue_sched: inflight_cnt out of range");
endmodule

// File: tb/tb_mem_issue_sched.sv
// Directed self-checking bench for mem_issue_sched.
`timescale 1ns/1ps
module tb_mem_issue_sched;
    localparam int unsigned DW = 248;
    localparam int unsigned RW = 7;
    localparam int unsigned IW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cnt;
    logic       idle;
    int         checks = 0;
    int         passed = 0;

    mem_issue_sched_if bus ();

    mem_issue_sched dut (
        .clock        (clk),
        .reset_n      (rst_n),
        .bus          (bus),
        .inflight_cnt (cnt),
        .sched_idle   (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk_data(input logic [RW-1:0] r);
        return {r, 234'h0, ~r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_isq(input logic v, input logic [RW-1:0] r);
        bus.isq_deq_valid = v;
        bus.isq_deq_robid = r;
        bus.isq_deq_data  = mk_data(r);
        bus.isq_deq_id    = r[IW-1:0];
    endtask

    task automatic set_resp(input logic v, input logic rep, input logic [RW-1:0] r);
        bus.lsu_resp_valid  = v;
        bus.lsu_resp_replay = rep;
        bus.lsu_resp_robid  = r;
        bus.lsu_resp_data   = mk_data(r);
        bus.lsu_resp_id     = r[IW-1:0];
    endtask

    task automatic complete(input logic [RW-1:0] r);
        set_resp(1'b1, 1'b0, r);
        tick();
        set_resp(1'b0, 1'b0, '0);
    endtask

    task automatic bounce(input logic [RW-1:0] r);
        set_resp(1'b1, 1'b1, r);
        tick();
        set_resp(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.flush_valid   = 1'b0;
        bus.flush_robid   = '0;
        set_resp(1'b0, 1'b0, '0);
        set_isq(1'b1, 7'h05);
        tick();
        tick();
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL reset_isq_ready: got %b want 0", bus.isq_deq_ready); else passed++;
        checks++; if (bus.lsu_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", bus.lsu_req_valid); else passed++;
        checks++; if (bus.lsu_req_data !== '0 || bus.lsu_req_robid !== '0 || bus.lsu_req_id !== '0)
            $display("FAIL reset_req_payload: got robid %h id %h want 0", bus.lsu_req_robid, bus.lsu_req_id); else passed++;
        checks++; if (bus.lsu_req_is_replay !== 1'b0) $display("FAIL reset_is_replay: got %b want 0", bus.lsu_req_is_replay); else passed++;
        checks++; if (cnt !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else passed++;
        rst_n = 1'b1;
        set_isq(1'b0, '0);
        tick();
        checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else passed++;
    endtask

    task automatic test_basic_issue();
        bus.lsu_req_ready = 1'b1;
        set_isq(1'b1, 7'h05);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b1) $display("FAIL basic_isq_ready: got %b want 1", bus.isq_deq_ready); else passed++;
        tick();
        set_isq(1'b0, '0);
        checks++; if (bus.lsu_req_valid !== 1'b1 || bus.lsu_req_robid !== 7'h05 || bus.lsu_req_is_replay !== 1'b0)
            $display("FAIL basic_req: got v=%b robid=%h rep=%b want v=1 robid=05 rep=0",
                     bus.lsu_req_valid, bus.lsu_req_robid, bus.lsu_req_is_replay); else passed++;
        checks++; if (bus.lsu_req_data !== mk_data(7'h05) || bus.lsu_req_id !== 4'h5)
            $display("FAIL basic_payload: got id=%h want 5", bus.lsu_req_id); else passed++;
        checks++; if (cnt !== 3'd1) $display("FAIL basic_cnt_issue: got %0d want 1", cnt); else passed++;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b0 || idle !== 1'b0)
            $display("FAIL basic_handoff: got v=%b idle=%b want v=0 idle=0", bus.lsu_req_valid, idle); else passed++;
        complete(7'h05);
        checks++; if (cnt !== 3'd0 || idle !== 1'b1)
            $display("FAIL basic_complete: got cnt=%0d idle=%b want cnt=0 idle=1", cnt, idle); else passed++;
    endtask

    task automatic test_credit_limit();
        bus.lsu_req_ready = 1'b0;
        set_isq(1'b1, 7'h01);
        tick();
        set_isq(1'b1, 7'h02);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL hold_isq_ready: got %b want 0", bus.isq_deq_ready); else passed++;
        tick();
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b1 || bus.lsu_req_robid !== 7'h01 || bus.lsu_req_data !== mk_data(7'h01))
            $display("FAIL hold_stable: got v=%b robid=%h want v=1 robid=01", bus.lsu_req_valid, bus.lsu_req_robid); else passed++;
        bus.lsu_req_ready = 1'b1;
        tick();
        set_isq(1'b1, 7'h03);
        tick();
        set_isq(1'b1, 7'h04);
        tick();
        checks++; if (cnt !== 3'd4 || bus.lsu_req_robid !== 7'h04)
            $display("FAIL credit_fill: got cnt=%0d robid=%h want cnt=4 robid=04", cnt, bus.lsu_req_robid); else passed++;
        set_isq(1'b1, 7'h05);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL credit_full_ready: got %b want 0", bus.isq_deq_ready); else passed++;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b0 || cnt !== 3'd4)
            $display("FAIL credit_no_5th: got v=%b cnt=%0d want v=0 cnt=4", bus.lsu_req_valid, cnt); else passed++;
        set_resp(1'b1, 1'b0, 7'h01);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL credit_same_cycle: got %b want 0", bus.isq_deq_ready); else passed++;
        tick();
        set_resp(1'b0, 1'b0, '0);
        #1;
        checks++; if (cnt !== 3'd3 || bus.isq_deq_ready !== 1'b1)
            $display("FAIL credit_freed: got cnt=%0d ready=%b want cnt=3 ready=1", cnt, bus.isq_deq_ready); else passed++;
        tick();
        set_isq(1'b0, '0);
        checks++; if (bus.lsu_req_robid !== 7'h05 || cnt !== 3'd4)
            $display("FAIL credit_5th_issue: got robid=%h cnt=%0d want robid=05 cnt=4", bus.lsu_req_robid, cnt); else passed++;
        complete(7'h02);
        complete(7'h03);
        complete(7'h04);
        complete(7'h05);
        checks++; if (cnt !== 3'd0 || idle !== 1'b1)
            $display("FAIL credit_drain: got cnt=%0d idle=%b want cnt=0 idle=1", cnt, idle); else passed++;
    endtask

    task automatic test_replay_priority();
        bus.lsu_req_ready = 1'b1;
        set_isq(1'b1, 7'h03);
        tick();
        set_isq(1'b0, '0);
        tick();
        bounce(7'h03);
        set_isq(1'b1, 7'h09);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0 || cnt !== 3'd1)
            $display("FAIL replay_block: got ready=%b cnt=%0d want ready=0 cnt=1", bus.isq_deq_ready, cnt); else passed++;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b1 || bus.lsu_req_robid !== 7'h03 || bus.lsu_req_is_replay !== 1'b1
                      || bus.lsu_req_data !== mk_data(7'h03) || bus.lsu_req_id !== 4'h3)
            $display("FAIL replay_issue: got v=%b robid=%h rep=%b want v=1 robid=03 rep=1",
                     bus.lsu_req_valid, bus.lsu_req_robid, bus.lsu_req_is_replay); else passed++;
        checks++; if (cnt !== 3'd1) $display("FAIL replay_cnt: got %0d want 1", cnt); else passed++;
        tick();
        set_isq(1'b0, '0);
        checks++; if (bus.lsu_req_robid !== 7'h09 || bus.lsu_req_is_replay !== 1'b0 || cnt !== 3'd2)
            $display("FAIL replay_then_isq: got robid=%h rep=%b cnt=%0d want robid=09 rep=0 cnt=2",
                     bus.lsu_req_robid, bus.lsu_req_is_replay, cnt); else passed++;
        tick();
        complete(7'h03);
        complete(7'h09);
    endtask

    task automatic test_wrap_age();
        bus.lsu_req_ready = 1'b1;
        set_isq(1'b1, 7'h01);
        tick();
        set_isq(1'b1, 7'h7E);
        tick();
        set_isq(1'b1, 7'h10);
        tick();
        set_isq(1'b0, '0);
        bus.lsu_req_ready = 1'b0;
        bounce(7'h01);
        bounce(7'h7E);
        checks++; if (cnt !== 3'd3 || bus.lsu_req_robid !== 7'h10)
            $display("FAIL wrap_setup: got cnt=%0d robid=%h want cnt=3 robid=10", cnt, bus.lsu_req_robid); else passed++;
        bus.lsu_req_ready = 1'b1;
        tick();
        checks++; if (bus.lsu_req_robid !== 7'h7E || bus.lsu_req_is_replay !== 1'b1)
            $display("FAIL wrap_oldest_first: got robid=%h rep=%b want robid=7e rep=1",
                     bus.lsu_req_robid, bus.lsu_req_is_replay); else passed++;
        tick();
        checks++; if (bus.lsu_req_robid !== 7'h01 || bus.lsu_req_is_replay !== 1'b1)
            $display("FAIL wrap_second: got robid=%h rep=%b want robid=01 rep=1",
                     bus.lsu_req_robid, bus.lsu_req_is_replay); else passed++;
        tick();
        complete(7'h10);
        complete(7'h7E);
        complete(7'h01);
        checks++; if (cnt !== 3'd0) $display("FAIL wrap_drain: got %0d want 0", cnt); else passed++;
    endtask

    task automatic test_flush();
        bus.lsu_req_ready = 1'b1;
        set_isq(1'b1, 7'h04);
        tick();
        set_isq(1'b1, 7'h08);
        tick();
        set_isq(1'b1, 7'h07);
        tick();
        set_isq(1'b1, 7'h06);
        tick();
        set_isq(1'b0, '0);
        bus.lsu_req_ready = 1'b0;
        bounce(7'h04);
        bounce(7'h08);
        checks++; if (cnt !== 3'd4 || bus.lsu_req_robid !== 7'h06)
            $display("FAIL flush_setup: got cnt=%0d robid=%h want cnt=4 robid=06", cnt, bus.lsu_req_robid); else passed++;
        bus.flush_valid = 1'b1;
        bus.flush_robid = 7'h05;
        set_resp(1'b1, 1'b1, 7'h07);
        set_isq(1'b1, 7'h0A);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL flush_isq_ready: got %b want 0", bus.isq_deq_ready); else passed++;
        tick();
        bus.flush_valid = 1'b0;
        set_resp(1'b0, 1'b0, '0);
        set_isq(1'b0, '0);
        checks++; if (bus.lsu_req_valid !== 1'b0) $display("FAIL flush_out_kill: got %b want 0", bus.lsu_req_valid); else passed++;
        checks++; if (cnt !== 3'd1) $display("FAIL flush_cnt: got %0d want 1", cnt); else passed++;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b1 || bus.lsu_req_robid !== 7'h04 || bus.lsu_req_is_replay !== 1'b1)
            $display("FAIL flush_survivor: got v=%b robid=%h rep=%b want v=1 robid=04 rep=1",
                     bus.lsu_req_valid, bus.lsu_req_robid, bus.lsu_req_is_replay); else passed++;
        bus.lsu_req_ready = 1'b1;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b0)
            $display("FAIL flush_no_extra: got v=%b robid=%h want v=0", bus.lsu_req_valid, bus.lsu_req_robid); else passed++;
        complete(7'h04);
        checks++; if (cnt !== 3'd0 || idle !== 1'b1)
            $display("FAIL flush_drain: got cnt=%0d idle=%b want cnt=0 idle=1", cnt, idle); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.lsu_req_ready = 1'b1;
        set_isq(1'b1, 7'h11);
        tick();
        set_isq(1'b1, 7'h12);
        tick();
        set_isq(1'b1, 7'h13);
        tick();
        set_isq(1'b0, '0);
        bus.lsu_req_ready = 1'b0;
        bounce(7'h11);
        bounce(7'h12);
        checks++; if (cnt !== 3'd3) $display("FAIL rstmid_setup: got %0d want 3", cnt); else passed++;
        rst_n = 1'b0;
        set_isq(1'b1, 7'h20);
        #1;
        checks++; if (bus.isq_deq_ready !== 1'b0) $display("FAIL rstmid_isq_ready: got %b want 0", bus.isq_deq_ready); else passed++;
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b0 || cnt !== 3'd0 || idle !== 1'b1)
            $display("FAIL rstmid_state: got v=%b cnt=%0d idle=%b want v=0 cnt=0 idle=1",
                     bus.lsu_req_valid, cnt, idle); else passed++;
        rst_n = 1'b1;
        set_isq(1'b0, '0);
        bus.lsu_req_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.lsu_req_valid !== 1'b0 || cnt !== 3'd0)
            $display("FAIL rstmid_replay_cleared: got v=%b cnt=%0d want v=0 cnt=0", bus.lsu_req_valid, cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_credit_limit();
        test_replay_priority();
        test_wrap_age();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
